// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between two requesters and the register file.
// The arbiter uses the slave view; the requesters/register file side uses master.
interface regfile_write_arbiter_if;
    logic        ReqA_Valid;
    logic        ReqA_Ready;
    logic [4:0]  ReqA_Reg;
    logic [63:0] ReqA_Data;
    logic        ReqB_Valid;
    logic        ReqB_Ready;
    logic [4:0]  ReqB_Reg;
    logic [63:0] ReqB_Data;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic        RegWr;
    logic [31:0] Pending;

    modport slave (
        input  ReqA_Valid, ReqA_Reg, ReqA_Data,
        input  ReqB_Valid, ReqB_Reg, ReqB_Data,
        output ReqA_Ready, ReqB_Ready,
        output RW, BusW, RegWr, Pending
    );

    modport master (
        output ReqA_Valid, ReqA_Reg, ReqA_Data,
        output ReqB_Valid, ReqB_Reg, ReqB_Data,
        input  ReqA_Ready, ReqB_Ready,
        input  RW, BusW, RegWr, Pending
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter in front of a 32-entry register file.
// Each requester owns a one-entry buffer; at most one buffer commits per cycle.
// Writes to X31 (XZR) are acknowledged and dropped.
module regfile_write_arbiter (
    input  logic                   Clk,
    input  logic                   Resetl,
    regfile_write_arbiter_if.slave bus
);
    typedef enum logic { BUF_EMPTY, BUF_FULL } buf_state_e;
    typedef enum logic { PRI_A, PRI_B } pri_e;

    localparam logic [4:0] XZR = 5'd31;

    buf_state_e  a_state_q, a_state_d, b_state_q, b_state_d;
    logic [4:0]  a_reg_q, a_reg_d, b_reg_q, b_reg_d;
    logic [63:0] a_data_q, a_data_d, b_data_q, b_data_d;
    pri_e        pri_q, pri_d;
    logic        older_is_b_q, older_is_b_d;
    logic [4:0]  rw_q, rw_d;
    logic [63:0] busw_q, busw_d;
    logic        regwr_q, regwr_d;

    logic a_full, b_full;
    logic grant_a, grant_b;
    logic acc_a, acc_b, load_a, load_b;
    logic [31:0] pending;

    assign a_full = (a_state_q == BUF_FULL);
    assign b_full = (b_state_q == BUF_FULL);

    // Grant selection from registered state only, so Ready never depends on Valid.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that skips an assignment would infer a latch.
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_full && b_full) begin
            // Same destination: oldest first keeps per-register write order; otherwise round-robin.
            if (a_reg_q == b_reg_q) grant_b = older_is_b_q;
            else                    grant_b = (pri_q == PRI_B);
            grant_a = !grant_b;
        end else begin
            grant_a = a_full;
            grant_b = b_full;
        end
    end

    assign bus.ReqA_Ready = Resetl & (!a_full | grant_a);
    assign bus.ReqB_Ready = Resetl & (!b_full | grant_b);

    assign acc_a  = bus.ReqA_Valid & bus.ReqA_Ready;
    assign acc_b  = bus.ReqB_Valid & bus.ReqB_Ready;
    assign load_a = acc_a & (bus.ReqA_Reg != XZR);
    assign load_b = acc_b & (bus.ReqB_Reg != XZR);

    // Next-state: buffer fill/drain, commit outputs, round-robin pointer and age bit.
    always_comb begin
        a_state_d    = a_state_q;
        a_reg_d      = a_reg_q;
        a_data_d     = a_data_q;
        b_state_d    = b_state_q;
        b_reg_d      = b_reg_q;
        b_data_d     = b_data_q;
        pri_d        = pri_q;
        older_is_b_d = older_is_b_q;
        rw_d         = rw_q;
        busw_d       = busw_q;
        regwr_d      = grant_a | grant_b;

        // A same-edge accept reloads a granted buffer instead of emptying it.
        if (load_a) begin
            a_state_d = BUF_FULL;
            a_reg_d   = bus.ReqA_Reg;
            a_data_d  = bus.ReqA_Data;
        end else if (grant_a) begin
            a_state_d = BUF_EMPTY;
        end

        if (load_b) begin
            b_state_d = BUF_FULL;
            b_reg_d   = bus.ReqB_Reg;
            b_data_d  = bus.ReqB_Data;
        end else if (grant_b) begin
            b_state_d = BUF_EMPTY;
        end

        if (grant_a) begin
            rw_d   = a_reg_q;
            busw_d = a_data_q;
        end else if (grant_b) begin
            rw_d   = b_reg_q;
            busw_d = b_data_q;
        end

        if (a_full && b_full) pri_d = grant_a ? PRI_B : PRI_A;

        // B is older only when A loads alone while B's entry survives this edge.
        if (load_a && !load_b)  older_is_b_d = b_full && !grant_b;
        else if (load_b)        older_is_b_d = 1'b0;
    end

    // One bit per register with a buffered, uncommitted write; forced low in reset.
    always_comb begin
        pending = '0;
        if (Resetl) begin
            if (a_full) pending[a_reg_q] = 1'b1;
            if (b_full) pending[b_reg_q] = 1'b1;
        end
    end

    assign bus.Pending = pending;
    assign bus.RW      = rw_q;
    assign bus.BusW    = busw_q;
    assign bus.RegWr   = regwr_q;

    // Control and commit-output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (!Resetl) begin
            a_state_q    <= BUF_EMPTY;
            b_state_q    <= BUF_EMPTY;
            pri_q        <= PRI_A;
            older_is_b_q <= 1'b0;
            rw_q         <= '0;
            busw_q       <= '0;
            regwr_q      <= 1'b0;
        end else begin
            a_state_q    <= a_state_d;
            b_state_q    <= b_state_d;
            pri_q        <= pri_d;
            older_is_b_q <= older_is_b_d;
            rw_q         <= rw_d;
            busw_q       <= busw_d;
            regwr_q      <= regwr_d;
        end
    end

    // Buffer payload registers.
    always_ff @(posedge Clk) begin
        // NOTE: payload is left unreset on purpose; it is only observed while its buffer state is FULL.
        a_reg_q  <= a_reg_d;
        a_data_q <= a_data_d;
        b_reg_q  <= b_reg_d;
        b_data_q <= b_data_d;
    end
endmodule
